// File: rtl/secded_encoder_pipe.sv
// ============================================================================
// Module   : secded_encoder_pipe
// Brief    : Two-stage SECDED encoder with valid/ready flow control,
//            one-shot error injection and a saturating output word counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module secded_encoder_pipe #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 16,
  localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CODE_W-1:0]  out_code,
  input  logic               inj_arm,
  input  logic [CODE_W-1:0]  inj_mask,
  output logic               inj_busy,
  output logic [COUNT_W-1:0] word_count
);

  // Parity bit k covers every data bit whose Hamming position has bit k set.
  function automatic logic [PAR_W-1:0] calc_par(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] par;
    int               idx;
    par = '0;
    idx = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < PAR_W; k++) begin
          if (p[k]) par[k] = par[k] ^ d[idx];
        end
        idx++;
      end
    end
    return par;
  endfunction

  function automatic logic [CODE_W-1:0] build_code(input logic [DATA_W-1:0] d,
                                                   input logic [PAR_W-1:0]  par);
    logic [CODE_W-1:0] code;
    int                idx;
    code = '0;
    idx  = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        code[p-1] = d[idx];
        idx++;
      end else begin
        for (int k = 0; k < PAR_W; k++) begin
          if (p == (1 << k)) code[p-1] = par[k];
        end
      end
    end
    code[CODE_W-1] = ^code[CODE_W-2:0];
    return code;
  endfunction

  logic [DATA_W-1:0]  r_s1_data;
  logic [PAR_W-1:0]   r_s1_par;
  logic               r_s1_v;
  logic               r_out_valid;
  logic [CODE_W-1:0]  r_out_code;
  logic               r_inj_busy;
  logic [CODE_W-1:0]  r_inj_mask;
  logic [COUNT_W-1:0] r_count;

  logic               w_s2_adv;
  logic               w_accept;
  logic               w_xfer;
  logic               w_pop;
  logic [CODE_W-1:0]  w_code;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_v || w_s2_adv;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_s1_v && w_s2_adv;
  assign w_pop    = r_out_valid && out_ready;
  // Mask goes in after overall parity so a single flip stays detectable downstream.
  assign w_code   = build_code(r_s1_data, r_s1_par) ^ (r_inj_busy ? r_inj_mask : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data   <= '0;
      r_s1_par    <= '0;
      r_s1_v      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_inj_busy  <= 1'b0;
      r_inj_mask  <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_s1_data <= in_data;
        r_s1_par  <= calc_par(in_data);
        r_s1_v    <= 1'b1;
      end else if (w_s2_adv) begin
        r_s1_v    <= 1'b0;
      end

      if (w_s2_adv) begin
        r_out_valid <= r_s1_v;
        if (r_s1_v) r_out_code <= w_code;
      end

      // Busy is sampled before the arm is taken, so a concurrent arm waits a transfer.
      if (w_xfer && r_inj_busy) begin
        r_inj_busy <= 1'b0;
      end else if (inj_arm && !r_inj_busy) begin
        r_inj_busy <= 1'b1;
        r_inj_mask <= inj_mask;
      end

      if (w_pop && (r_count != {COUNT_W{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_code   = r_out_code;
  assign inj_busy   = r_inj_busy;
  assign word_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_secded_encoder_pipe.sv
// ============================================================================
// Module   : tb_secded_encoder_pipe
// Brief    : Directed self-checking bench for secded_encoder_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_secded_encoder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_code;
  logic        inj_arm;
  logic [12:0] inj_mask;
  logic        inj_busy;
  logic [15:0] wc;

  logic        c4_in_ready;
  logic        c4_out_valid;
  logic [12:0] c4_out_code;
  logic        c4_inj_busy;
  logic [3:0]  wc4;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] in_data32;
  logic        out_valid32;
  logic        out_ready32;
  logic [38:0] out_code32;
  logic        inj_busy32;
  logic [15:0] wc32;

  int n_cmp = 0;
  int n_err = 0;

  secded_encoder_pipe #(.DATA_W(8), .COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_busy(inj_busy), .word_count(wc)
  );

  secded_encoder_pipe #(.DATA_W(8), .COUNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data),
    .out_valid(c4_out_valid), .out_ready(out_ready), .out_code(c4_out_code),
    .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_busy(c4_inj_busy), .word_count(wc4)
  );

  secded_encoder_pipe #(.DATA_W(32), .COUNT_W(16)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_code(out_code32),
    .inj_arm(1'b0), .inj_mask(39'd0), .inj_busy(inj_busy32), .word_count(wc32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: scatter data into non-power-of-two positions, then solve each
  // parity position so that its covered group (including itself) is even.
  function automatic logic [63:0] ref_code(input logic [63:0] d, input int dw);
    logic [63:0] code;
    int          pw;
    int          cw;
    int          j;
    logic        par;
    pw = 0;
    while ((1 << pw) < dw + pw + 1) pw++;
    cw   = dw + pw + 1;
    code = '0;
    j    = 0;
    for (int p = 1; p < cw; p++) begin
      if ((p & (p - 1)) != 0) begin
        code[p-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < pw; k++) begin
      par = 1'b0;
      for (int p = 1; p < cw; p++) if (((p >> k) & 1) == 1) par = par ^ code[p-1];
      code[(1 << k) - 1] = par;
    end
    code[cw-1] = ^code;
    return code;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard active during streaming and backpressure phases.
  logic        sb_en = 1'b0;
  logic [63:0] exp_q[$];
  int          n_pop = 0;
  int          run = 0;
  int          max_run = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (in_valid && in_ready) exp_q.push_back(ref_code({56'd0, in_data}, 8));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("sb_extra_word", 64'(out_code), 64'hDEAD);
        else check_eq("sb_data", 64'(out_code), exp_q.pop_front());
        n_pop++;
      end
      if (out_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
  end

  task automatic one_word(input logic [7:0] d, input logic [12:0] exp, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_code"}, 64'(out_code), 64'(exp));
    tick();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] held;
    logic        saw_low;
    logic        acc;
    logic [31:0] d32;
    int          i;
    int          cyc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    inj_arm = 1'b0; inj_mask = '0;
    in_valid32 = 1'b0; in_data32 = '0; out_ready32 = 1'b1;

    // Reset and basic encode
    tick();
    tick();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_code", 64'(out_code), 64'd0);
    check_eq("rst_inj_busy", 64'(inj_busy), 64'd0);
    check_eq("rst_word_count", 64'(wc), 64'd0);
    one_word(8'h0C, 13'h1061, "enc_0c");
    one_word(8'hFF, 13'h0F77, "enc_ff");
    one_word(8'h00, 13'h0000, "enc_00");
    check_eq("basic_word_count", 64'(wc), 64'd3);

    // Streaming 0x00..0xFF
    reset_pulse();
    exp_q.delete(); n_pop = 0; run = 0; max_run = 0;
    sb_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      in_valid = 1'b1;
      in_data  = k[7:0];
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    sb_en = 1'b0;
    check_eq("stream_pops", 64'(n_pop), 64'd256);
    check_eq("stream_no_bubble", 64'(max_run), 64'd256);
    check_eq("stream_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("stream_word_count", 64'(wc), 64'd256);

    // Backpressure mid-stream
    reset_pulse();
    exp_q.delete(); n_pop = 0;
    sb_en = 1'b1; saw_low = 1'b0; held = '0;
    i = 0; cyc = 0;
    while (i < 20 && cyc < 200) begin
      out_ready = !(cyc >= 8 && cyc < 13);
      in_valid  = 1'b1;
      in_data   = 8'h30 + i[7:0];
      #1;
      if (!out_ready) begin
        if (cyc == 8) held = out_code;
        else check_eq("bp_hold_code", 64'(out_code), 64'(held));
        check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
        if (!in_ready) saw_low = 1'b1;
      end
      acc = in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    sb_en = 1'b0;
    check_eq("bp_in_ready_low", 64'(saw_low), 64'd1);
    check_eq("bp_pops", 64'(n_pop), 64'd20);
    check_eq("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Injection
    reset_pulse();
    inj_arm = 1'b1; inj_mask = 13'h0001;
    check_eq("inj_busy_pre", 64'(inj_busy), 64'd0);
    tick();
    inj_arm = 1'b0;
    check_eq("inj_busy_armed", 64'(inj_busy), 64'd1);
    inj_arm = 1'b1; inj_mask = 13'h1000;
    tick();
    inj_arm = 1'b0; inj_mask = '0;
    check_eq("inj_busy_rearm", 64'(inj_busy), 64'd1);
    in_valid = 1'b1; in_data = 8'h0C;
    tick();
    check_eq("inj_busy_s1", 64'(inj_busy), 64'd1);
    tick();
    in_valid = 1'b0;
    check_eq("inj_busy_clear", 64'(inj_busy), 64'd0);
    check_eq("inj_first_code", 64'(out_code), 64'h1060);
    tick();
    check_eq("inj_second_code", 64'(out_code), 64'h1061);
    tick();

    // Arm concurrent with S1->S2 transfer
    in_valid = 1'b1; in_data = 8'h0C;
    tick();
    in_data = 8'hFF; inj_arm = 1'b1; inj_mask = 13'h0003;
    tick();
    inj_arm = 1'b0; in_valid = 1'b0;
    check_eq("conc_clean_code", 64'(out_code), 64'h1061);
    check_eq("conc_busy", 64'(inj_busy), 64'd1);
    tick();
    check_eq("conc_masked_code", 64'(out_code), 64'h0F74);
    check_eq("conc_busy_clear", 64'(inj_busy), 64'd0);
    tick();

    // Reset mid-flight with injection armed
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    inj_arm = 1'b1; inj_mask = 13'h0005;
    tick();
    inj_arm = 1'b0;
    check_eq("full_busy", 64'(inj_busy), 64'd1);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_busy", 64'(inj_busy), 64'd0);
    check_eq("midrst_word_count", 64'(wc), 64'd0);
    out_ready = 1'b1;
    one_word(8'h0C, 13'h1061, "post_rst");

    // Counter saturation
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = k[7:0];
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check_eq("count16_value", 64'(wc), 64'd21);
    check_eq("count4_saturated", 64'(wc4), 64'd15);

    // DATA_W=32 against the reference model
    for (int k = 0; k < 10; k++) begin
      d32 = (k == 0) ? 32'h0000_0000 : (k == 1) ? 32'hFFFF_FFFF : $urandom;
      in_valid32 = 1'b1;
      in_data32  = d32;
      tick();
      in_valid32 = 1'b0;
      tick();
      check_eq("w32_valid", 64'(out_valid32), 64'd1);
      check_eq("w32_code", 64'(out_code32), ref_code({32'd0, d32}, 32));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
